// File: rtl/flag_stack_if.sv
// Flag save/restore bus between the control unit, the flag register and flag_stack.
interface flag_stack_if #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic          push;
  logic          pop;
  logic          Ci;
  logic          Ni;
  logic          Zi;
  logic          Vi;
  logic          errClr;
  logic          Cbk;
  logic          Nbk;
  logic          Zbk;
  logic          Vbk;
  logic          flagRest;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflowErr;
  logic          underflowErr;

  // Control unit / flag register side: drives requests and live flags.
  modport master (
    output push, pop, Ci, Ni, Zi, Vi, errClr,
    input  Cbk, Nbk, Zbk, Vbk, flagRest, count, full, empty,
           overflowErr, underflowErr
  );

  // Stack side: consumes requests, produces the restore bus and status.
  modport slave (
    input  push, pop, Ci, Ni, Zi, Vi, errClr,
    output Cbk, Nbk, Zbk, Vbk, flagRest, count, full, empty,
           overflowErr, underflowErr
  );
endinterface

// File: rtl/flag_stack.sv
// LIFO save/restore stack for the C/N/Z/V condition flags.
// Push captures the live flags; pop returns the most recent set on the
// registered backup bus together with a one-cycle flagRest strobe.
module flag_stack #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic        clk,
  input logic        rst,
  flag_stack_if.slave bus
);

  // Entry layout is {C,N,Z,V}.
  logic [3:0]    r_entry [DEPTH];
  logic [CW-1:0] r_sp;
  logic [3:0]    r_bk;
  logic          r_flag_rest;
  logic          r_ovf;
  logic          r_unf;

  logic [3:0]    w_flags;
  logic [3:0]    w_top;
  logic [CW-1:0] w_top_idx;
  logic          w_full;
  logic          w_empty;
  logic          w_push_only;
  logic          w_pop_only;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_swap;
  logic          w_bypass;
  logic          w_ovf_evt;
  logic          w_unf_evt;

  assign w_flags   = {bus.Ci, bus.Ni, bus.Zi, bus.Vi};
  assign w_full    = (r_sp == CW'(DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_top_idx = r_sp - CW'(1);

  assign w_push_only = bus.push & ~bus.pop;
  assign w_pop_only  = bus.pop & ~bus.push;
  assign w_do_push   = w_push_only & ~w_full;
  assign w_do_pop    = w_pop_only & ~w_empty;
  // Push and pop together replace the top in place (old top goes out).
  assign w_swap      = bus.push & bus.pop & ~w_empty;
  // Push and pop together on an empty stack pass the live flags straight through.
  assign w_bypass    = bus.push & bus.pop & w_empty;
  assign w_ovf_evt   = w_push_only & w_full;
  assign w_unf_evt   = w_pop_only & w_empty;

  // Select the current top entry; compare-based so the index never leaves range.
  always_comb begin
    w_top = 4'h0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_top_idx == CW'(i)) begin
        w_top = r_entry[i];
      end
    end
  end

  // Per-entry storage: written by a plain push at sp, or by a swap at sp-1.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic w_wr;
      assign w_wr = (w_do_push && (r_sp == CW'(gi))) ||
                    (w_swap && (w_top_idx == CW'(gi)));

      // Capture live flags into this slot when selected.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_entry[gi] <= 4'h0;
        end else if (w_wr) begin
          r_entry[gi] <= w_flags;
        end
      end
    end
  endgenerate

  // Stack pointer: moves only on a single-sided accepted operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + CW'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - CW'(1);
    end
  end

  // Restore bus and strobe: bus holds between accepted pops, strobe is one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bk        <= 4'h0;
      r_flag_rest <= 1'b0;
    end else begin
      r_flag_rest <= w_do_pop | w_swap | w_bypass;
      if (w_do_pop || w_swap) begin
        r_bk <= w_top;
      end else if (w_bypass) begin
        r_bk <= w_flags;
      end
    end
  end

  // Sticky error bits; a new event in the clear cycle keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt | (r_ovf & ~bus.errClr);
      r_unf <= w_unf_evt | (r_unf & ~bus.errClr);
    end
  end

  assign bus.Cbk          = r_bk[3];
  assign bus.Nbk          = r_bk[2];
  assign bus.Zbk          = r_bk[1];
  assign bus.Vbk          = r_bk[0];
  assign bus.flagRest     = r_flag_rest;
  assign bus.count        = r_sp;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.overflowErr  = r_ovf;
  assign bus.underflowErr = r_unf;

endmodule

// File: doc/flag_stack.md
# flag_stack

Hardware save/restore stack for the Minx16 C/N/Z/V condition flags. It captures the live flag outputs on interrupt or call entry (`push`) and hands them back to the flag register on return (`pop`). On return it drives the `Cbk/Nbk/Zbk/Vbk` backup bus and a one-cycle `flagRest` strobe. It sits between the control unit and the flag register, and is the producer side of the flag-register restore interface.

## Interface
- `DEPTH`, default 4: number of saved flag sets; legal range 2..16.
- `CW`, default `$clog2(DEPTH+1)`: width of `count`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `push`  in  1  save current flags this cycle.
- `pop`  in  1  restore most recent saved flags.
- `Ci`, `Ni`, `Zi`, `Vi`  in  1 each  live flags, taken from the flag register outputs.
- `errClr`  in  1  clear the sticky error bits.
- `Cbk`, `Nbk`, `Zbk`, `Vbk`  out  1 each  restored flag values, registered.
- `flagRest`  out  1  restore strobe to the flag register; a one-cycle pulse.
- `count`  out  CW  number of valid entries.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflowErr`  out  1  sticky; a push was dropped because the stack was full.
- `underflowErr`  out  1  sticky; a pop was issued while the stack was empty.

## Operation
Storage and pointer:
- Storage is DEPTH x 4-bit entries {C,N,Z,V}, used LIFO.
- `sp` holds the entry count and is the same value as `count`.

Per-edge action (all actions take effect on the rising edge of `clk`):
- **push only, not full:** `entry[sp] <= {Ci,Ni,Zi,Vi}`; `sp <= sp+1`.
- **push only, full:** the entry is dropped, `sp` is unchanged, `overflowErr <= 1`.
- **pop only, not empty:**
  - `{Cbk,Nbk,Zbk,Vbk} <= entry[sp-1]`
  - `sp <= sp-1`
  - `flagRest <= 1`
- **pop only, empty:** `sp` is unchanged, the backup bus holds its value, `flagRest` stays 0, `underflowErr <= 1`.
- **push and pop, not empty:**
  - The backup bus gets `entry[sp-1]` (the old top).
  - `entry[sp-1] <= {Ci,Ni,Zi,Vi}`.
  - `sp` is unchanged and `flagRest <= 1`.
  - No error is flagged, even when the stack is full.
- **push and pop, empty:**
  - Bypass: the backup bus gets `{Ci,Ni,Zi,Vi}`.
  - `flagRest <= 1`, `sp` stays 0, no error.
- **neither:** state holds and `flagRest <= 0`.

Other rules:
- `flagRest` is 1 only in the cycle after an accepted pop. It is never held across cycles, including on back-to-back pops, where it is 1 in each following cycle.
- Error bits:
  - `errClr` clears both sticky bits.
  - If a new error event occurs in the same cycle as `errClr`, the error wins and the bit stays 1.
- The backup bus holds its last value until the next accepted pop.
- The block does not check `LD` on the flag register. The flag register gives `LD` priority over `flagRest`, so the control unit must not assert `LD` in the `flagRest` cycle. A restore lost this way is not retried.
- `full` and `empty` are decoded combinationally from `sp`.

## Timing
- Reset (`rst`=1 at an edge):
  - `sp`=0 and every entry = 0.
  - `Cbk`/`Nbk`/`Zbk`/`Vbk`=0 and `flagRest`=0.
  - `overflowErr`=`underflowErr`=0.
  - `count`=0, `empty`=1, `full`=0.
- Reset dominates `push`/`pop` in the same cycle. A reset mid-sequence discards all saved entries and any pending strobe.
- Push latency: flags sampled at edge N can be popped as early as edge N+1.
- Pop latency, from `pop` sampled at edge N:
  - The backup bus and `flagRest` are valid during cycle N+1.
  - The flag register updates at edge N+2.
- `count`, `full` and `empty` reflect an operation one edge after it is sampled.
- There are no combinational paths from inputs to `Cbk`/`Nbk`/`Zbk`/`Vbk`/`flagRest`.

## Test plan
- **Reset:** hold `rst` 2 cycles with `push`=1 -> all outputs 0, `empty`=1, `count`=0.
- **LIFO order:** push {1,0,0,0}, {0,1,0,0}, {0,0,1,0}, {0,0,0,1}, then 4 pops -> backup bus returns {0,0,0,1}, {0,0,1,0}, {0,1,0,0}, {1,0,0,0}; `flagRest` is 1 in each of the 4 cycles after the pops; then `empty`=1.
- **Overflow:** with DEPTH=4, issue 5 pushes -> `full`=1, `count`=4, `overflowErr`=1, and the 5th value is never returned. Then `errClr` -> `overflowErr`=0.
- **Underflow:** pop while empty -> `flagRest` stays 0, the backup bus is unchanged, `underflowErr`=1. Assert `errClr` together with a second empty pop -> `underflowErr` stays 1.
- **Simultaneous push and pop:**
  - With count=2, top={1,1,0,0}, push+pop with inputs {0,0,1,1} -> bus={1,1,0,0}, `flagRest` pulses, count stays 2; the next pop returns {0,0,1,1}.
  - While empty, push+pop with {1,0,1,0} -> bus={1,0,1,0}, `flagRest`=1, count=0.
- **Reset mid-operation:** 3 pushes, pop, then `rst` in the following cycle -> `flagRest` drops to 0 at the reset edge, `count`=0, and a subsequent pop sets `underflowErr`.
